// File: rtl/pwm_meas10bit.sv
// PWM frame measurement: high time and period of each
// rise-to-rise frame, with a dead-line timeout for 0%/100% duty.
module pwm_meas10bit #(
  parameter int TIMEOUT = 2048
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        PWM_in,
  output logic [9:0]  duty,
  output logic [10:0] period,
  output logic        vld,
  output logic        stuck
);

  typedef enum logic [1:0] {
    IDLE,
    MEAS,
    STUCK
  } state_t;

  localparam logic [11:0] TO = 12'(TIMEOUT);

  state_t      state;
  logic        s1, s2, s3;
  logic [10:0] per_cnt;
  logic [10:0] high_cnt;
  logic [11:0] idle_cnt;
  logic        rise, fall, any_edge;
  logic        timeout;
  logic [9:0]  duty_sat;

  assign rise     = s2 & ~s3;
  assign fall     = ~s2 & s3;
  assign any_edge = rise | fall;
  assign timeout  = (idle_cnt == TO) & ~any_edge;
  assign duty_sat = (high_cnt > 11'd1023)
                  ? 10'd1023 : high_cnt[9:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= PWM_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_cnt  <= '0;
      high_cnt <= '0;
    end else if (rise) begin
      per_cnt  <= 11'd1;
      high_cnt <= 11'd1;
    end else begin
      if (per_cnt != 11'h7ff)
        per_cnt <= per_cnt + 11'd1;
      if (s2 && high_cnt != 11'h7ff)
        high_cnt <= high_cnt + 11'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      idle_cnt <= '0;
    else if (any_edge)
      idle_cnt <= '0;
    else if (idle_cnt != 12'hfff)
      idle_cnt <= idle_cnt + 12'd1;
  end

  // Rise is checked first; a timeout can never share its cycle anyway.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      duty   <= '0;
      period <= '0;
      vld    <= 1'b0;
      stuck  <= 1'b0;
    end else begin
      vld <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rise) begin
            state <= MEAS;
          end else if (timeout) begin
            state  <= STUCK;
            duty   <= s2 ? 10'd1023 : 10'd0;
            period <= '0;
            stuck  <= 1'b1;
            vld    <= 1'b1;
          end
        end
        MEAS: begin
          if (rise) begin
            duty   <= duty_sat;
            period <= per_cnt;
            stuck  <= 1'b0;
            vld    <= 1'b1;
          end else if (timeout) begin
            state  <= STUCK;
            duty   <= s2 ? 10'd1023 : 10'd0;
            period <= '0;
            stuck  <= 1'b1;
            vld    <= 1'b1;
          end
        end
        STUCK: begin
          if (rise)
            state <= MEAS;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_meas10bit.sv
// Directed bench for pwm_meas10bit: three instances with
// TIMEOUT 2048, 1500 and 4095.
module tb_pwm_meas10bit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pa = 1'b0, pb = 1'b0, pc = 1'b0;

  logic [9:0]  duty_a, duty_b, duty_c;
  logic [10:0] period_a, period_b, period_c;
  logic        vld_a, vld_b, vld_c;
  logic        stuck_a, stuck_b, stuck_c;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  int a_n = 0, a_cyc = 0, a_prev = 0;
  int a_duty = 0, a_per = 0, a_stk = 0;
  int b_n = 0, b_duty = 0, b_per = 0, b_stk = 0;
  int c_n = 0, c_duty = 0, c_per = 0, c_stk = 0;

  pwm_meas10bit u_a (
    .clk(clk), .rst_n(rst_n), .PWM_in(pa),
    .duty(duty_a), .period(period_a),
    .vld(vld_a), .stuck(stuck_a)
  );

  pwm_meas10bit #(.TIMEOUT(1500)) u_b (
    .clk(clk), .rst_n(rst_n), .PWM_in(pb),
    .duty(duty_b), .period(period_b),
    .vld(vld_b), .stuck(stuck_b)
  );

  pwm_meas10bit #(.TIMEOUT(4095)) u_c (
    .clk(clk), .rst_n(rst_n), .PWM_in(pc),
    .duty(duty_c), .period(period_c),
    .vld(vld_c), .stuck(stuck_c)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst_n) begin
      a_n = 0;
      b_n = 0;
      c_n = 0;
    end else begin
      if (vld_a) begin
        a_n++;
        a_prev = a_cyc;
        a_cyc  = cyc;
        a_duty = int'(duty_a);
        a_per  = int'(period_a);
        a_stk  = int'(stuck_a);
      end
      if (vld_b) begin
        b_n++;
        b_duty = int'(duty_b);
        b_per  = int'(period_b);
        b_stk  = int'(stuck_b);
      end
      if (vld_c) begin
        c_n++;
        c_duty = int'(duty_c);
        c_per  = int'(period_c);
        c_stk  = int'(stuck_c);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag,
                     input int obs, input int exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0d expected %0d",
                tag, obs, exp);
  endtask

  task automatic frame(input int sel,
                       input int hi, input int per);
    case (sel)
      0: pa = 1'b1;
      1: pb = 1'b1;
      default: pc = 1'b1;
    endcase
    step(hi);
    case (sel)
      0: pa = 1'b0;
      1: pb = 1'b0;
      default: pc = 1'b0;
    endcase
    step(per - hi);
  endtask

  initial begin
    int t0;
    int n0;
    step(3);
    chk("rst_duty", int'(duty_a), 0);
    chk("rst_period", int'(period_a), 0);
    chk("rst_vld", int'(vld_a), 0);
    chk("rst_stuck", int'(stuck_a), 0);
    rst_n = 1'b1;
    step(5);

    // loopback 512: rises 2..4 capture
    repeat (4) frame(0, 512, 1024);
    chk("lb_count", a_n, 3);
    chk("lb_duty", a_duty, 512);
    chk("lb_period", a_per, 1024);
    chk("lb_stuck", a_stk, 0);
    chk("lb_spacing", a_cyc - a_prev, 1024);

    repeat (2) frame(0, 1023, 1024);
    frame(0, 1, 1024);
    chk("d1023_duty", a_duty, 1023);
    chk("d1023_period", a_per, 1024);
    frame(0, 1, 1024);
    chk("d1_duty", a_duty, 1);
    chk("d1_period", a_per, 1024);
    chk("d1_count", a_n, 7);

    // two frames at 300, then the line dies low
    frame(0, 300, 1024);
    pa = 1'b1;
    step(300);
    pa = 1'b0;
    t0 = cyc;
    n0 = a_n;
    for (int i = 0; i < 3000 && a_n == n0; i++)
      step(1);
    chk("lo_duty", a_duty, 0);
    chk("lo_period", a_per, 0);
    chk("lo_stuck", a_stk, 1);
    // drop sampled +1, fall cycle +2, idle 0..2048, vld reg +1
    chk("lo_latency", a_cyc - t0, 2052);
    step(20);
    n0 = a_n;
    frame(0, 300, 1024);
    chk("resume_novld", a_n, n0);
    chk("resume_stuck_hold", int'(stuck_a), 1);
    frame(0, 300, 1024);
    chk("resume_duty", a_duty, 300);
    chk("resume_stuck_clr", int'(stuck_a), 0);
    chk("resume_count", a_n, n0 + 1);

    // mid-frame reset during 512 loopback
    frame(0, 512, 1024);
    frame(0, 512, 1024);
    pa = 1'b1;
    step(200);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_duty", int'(duty_a), 0);
    chk("mid_rst_period", int'(period_a), 0);
    chk("mid_rst_vld", int'(vld_a), 0);
    chk("mid_rst_stuck", int'(stuck_a), 0);
    pa = 1'b0;
    pb = 1'b1;
    step(3);
    rst_n = 1'b1;
    step(3);

    frame(0, 512, 1024);
    chk("post_rst_arm", a_n, 0);
    frame(0, 512, 1024);
    chk("post_rst_count", a_n, 1);
    chk("post_rst_duty", a_duty, 512);
    chk("post_rst_period", a_per, 1024);

    // B was held high since reset release
    chk("hi_count", b_n, 1);
    chk("hi_duty", b_duty, 1023);
    chk("hi_period", b_per, 0);
    chk("hi_stuck", b_stk, 1);

    frame(2, 100, 200);
    frame(2, 1500, 1800);
    frame(2, 3000, 4000);
    chk("long_hi_duty", c_duty, 1023);
    chk("long_hi_period", c_per, 1800);
    frame(2, 100, 200);
    chk("sat_duty", c_duty, 1023);
    chk("sat_period", c_per, 2047);
    chk("sat_stuck", c_stk, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
